// File: rtl/csr_idx_fetch.sv
// csr_idx_fetch: streams a CSR column-index array from memory and feeds the SpMV vector file.
//   clk, rst_n         : clock, asynchronous active-low reset
//   spmv_init          : synchronous abort/clear
//   start, idx_pntr,
//   nnz_cnt            : begin a fetch of nnz_cnt 16-bit indices starting at byte address idx_pntr
//   mem_req_*          : request channel (val/rdy, tag, 8-byte-aligned address)
//   mem_resp_*         : response channel (always accepted, may return out of order)
//   col_idx_*          : packed CHANNELS-wide index groups on a val/rdy handshake
//   busy, done         : not-idle flag, one-cycle completion pulse
module csr_idx_fetch #(
    parameter int unsigned CHANNELS  = 16,
    parameter int unsigned IDX_W     = 16,
    parameter int unsigned MAX_OUTST = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                spmv_init,
    input  logic                start,
    input  logic [39:0]         idx_pntr,
    input  logic [15:0]         nnz_cnt,
    input  logic                mem_req_rdy,
    output logic                mem_req_val,
    output logic [5:0]          mem_req_transid,
    output logic [39:0]         mem_req_addr,
    input  logic                mem_resp_val,
    input  logic [5:0]          mem_resp_transid,
    input  logic [63:0]         mem_resp_data,
    output logic                col_idx_val,
    input  logic                col_idx_rdy,
    output logic [IDX_W-1:0]    col_idx_out [CHANNELS-1:0],
    output logic [CHANNELS-1:0] col_idx_mask,
    output logic                col_idx_last,
    output logic                busy,
    output logic                done
);
    localparam int unsigned SlotW       = $clog2(MAX_OUTST);
    localparam int unsigned OutW        = $clog2(MAX_OUTST + 1);
    localparam int unsigned BeatsPerGrp = CHANNELS / 4;
    localparam int unsigned PosW        = (BeatsPerGrp > 1) ? $clog2(BeatsPerGrp) : 1;

    typedef enum logic [1:0] {StIdle, StFetch, StAbort} state_e;
    state_e state_q;

    logic [15:0]         nnz_q, nb_q, ng_q, req_k_q, drain_q, grp_q;
    logic [39:0]         addr_q;
    logic [OutW-1:0]     outst_q, outst_d;
    logic [63:0]         rob_data_q [MAX_OUTST];
    logic [MAX_OUTST-1:0] rob_vld_q;
    logic [PosW-1:0]     pos_q;
    logic [CHANNELS-1:0] last_mask_q, mask_q, start_mask;
    logic                val_q, last_q, done_q;
    logic [31:0]         rem_lanes;
    logic [SlotW-1:0]    req_slot, drain_slot, resp_slot;
    logic                req_fire, pop, hs, grp_full;
    logic                unused_bits;

    assign unused_bits = ^{idx_pntr[2:0], mem_resp_transid[5:SlotW]};

    assign req_slot   = req_k_q[SlotW-1:0];
    assign drain_slot = drain_q[SlotW-1:0];
    assign resp_slot  = mem_resp_transid[SlotW-1:0];

    // The in-flight window check keeps a tag from being reissued while its previous beat is
    // still in flight but its slot has not yet been written.
    assign mem_req_val = (state_q == StFetch) && (req_k_q < nb_q) &&
                         (outst_q < OutW'(MAX_OUTST)) && !rob_vld_q[req_slot] &&
                         ((req_k_q - drain_q) < 16'(MAX_OUTST));
    assign mem_req_transid = 6'(req_slot);
    assign mem_req_addr    = addr_q;
    assign req_fire        = mem_req_val & mem_req_rdy;

    // Single group buffer: packing waits until the presented group is consumed.
    assign pop      = (state_q == StFetch) && rob_vld_q[drain_slot] && !val_q;
    assign hs       = val_q & col_idx_rdy;
    assign grp_full = (pos_q == PosW'(BeatsPerGrp - 1)) || (drain_q == nb_q - 16'd1);
    assign outst_d  = outst_q + OutW'(req_fire) - OutW'(mem_resp_val);

    assign rem_lanes = 32'(nnz_cnt) % CHANNELS;
    always_comb begin
        start_mask = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            start_mask[i] = (rem_lanes == 32'd0) || (32'(i) < rem_lanes);
        end
    end

    assign col_idx_val  = val_q;
    assign col_idx_mask = mask_q;
    assign col_idx_last = last_q;
    assign busy         = (state_q != StIdle);
    assign done         = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            nnz_q       <= '0;
            nb_q        <= '0;
            ng_q        <= '0;
            req_k_q     <= '0;
            drain_q     <= '0;
            grp_q       <= '0;
            addr_q      <= '0;
            outst_q     <= '0;
            rob_vld_q   <= '0;
            pos_q       <= '0;
            last_mask_q <= '0;
            mask_q      <= '0;
            val_q       <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) rob_data_q[i] <= '0;
            for (int i = 0; i < CHANNELS; i++) col_idx_out[i] <= '0;
        end else begin
            done_q  <= 1'b0;
            outst_q <= outst_d;
            if (spmv_init) begin
                // Late responses still have to drain before the tags are reusable.
                state_q   <= (outst_d != '0) ? StAbort : StIdle;
                rob_vld_q <= '0;
                val_q     <= 1'b0;
                mask_q    <= '0;
                last_q    <= 1'b0;
                for (int i = 0; i < CHANNELS; i++) col_idx_out[i] <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start) begin
                            if (nnz_cnt == 16'd0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q     <= StFetch;
                                nnz_q       <= nnz_cnt;
                                nb_q        <= 16'((32'(nnz_cnt) + 32'd3) >> 2);
                                ng_q        <= 16'((32'(nnz_cnt) + CHANNELS - 1) / CHANNELS);
                                last_mask_q <= start_mask;
                                addr_q      <= {idx_pntr[39:3], 3'b000};
                                req_k_q     <= '0;
                                drain_q     <= '0;
                                grp_q       <= '0;
                                pos_q       <= '0;
                            end
                        end
                    end
                    StFetch: begin
                        if (req_fire) begin
                            req_k_q <= req_k_q + 16'd1;
                            addr_q  <= addr_q + 40'd8;
                        end
                        if (mem_resp_val) begin
                            rob_data_q[resp_slot] <= mem_resp_data;
                            rob_vld_q[resp_slot]  <= 1'b1;
                        end
                        if (pop) begin
                            rob_vld_q[drain_slot] <= 1'b0;
                            drain_q <= drain_q + 16'd1;
                            pos_q   <= grp_full ? '0 : pos_q + PosW'(1);
                            for (int i = 0; i < CHANNELS; i++) begin
                                if (32'(pos_q) == 32'(i / 4)) begin
                                    // Indices past nnz inside the final beat are zeroed.
                                    if ({14'd0, drain_q, 2'b00} + 32'(i % 4) < {16'd0, nnz_q}) begin
                                        col_idx_out[i] <=
                                            rob_data_q[drain_slot][IDX_W*(i%4) +: IDX_W];
                                    end else begin
                                        col_idx_out[i] <= '0;
                                    end
                                end
                            end
                            if (grp_full) begin
                                val_q  <= 1'b1;
                                last_q <= (grp_q == ng_q - 16'd1);
                                mask_q <= (grp_q == ng_q - 16'd1) ? last_mask_q : '1;
                            end
                        end
                        if (hs) begin
                            val_q  <= 1'b0;
                            mask_q <= '0;
                            last_q <= 1'b0;
                            grp_q  <= grp_q + 16'd1;
                            for (int i = 0; i < CHANNELS; i++) col_idx_out[i] <= '0;
                            if (last_q) begin
                                state_q <= StIdle;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    StAbort: begin
                        if (outst_d == '0) state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_csr_idx_fetch.sv
module tb_csr_idx_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        spmv_init, start;
    logic [39:0] idx_pntr;
    logic [15:0] nnz_cnt;
    logic        mem_req_rdy, mem_req_val;
    logic [5:0]  mem_req_transid;
    logic [39:0] mem_req_addr;
    logic        mem_resp_val;
    logic [5:0]  mem_resp_transid;
    logic [63:0] mem_resp_data;
    logic        col_idx_val, col_idx_rdy;
    logic [15:0] col_idx_out [15:0];
    logic [15:0] col_idx_mask;
    logic        col_idx_last, busy, done;

    logic [255:0] obs_lanes;
    logic [15:0]  mem [0:1023];
    int errors = 0;
    int checks = 0;

    csr_idx_fetch #(.CHANNELS(16), .IDX_W(16), .MAX_OUTST(8)) dut (
        .clk(clk), .rst_n(rst_n), .spmv_init(spmv_init), .start(start),
        .idx_pntr(idx_pntr), .nnz_cnt(nnz_cnt),
        .mem_req_rdy(mem_req_rdy), .mem_req_val(mem_req_val),
        .mem_req_transid(mem_req_transid), .mem_req_addr(mem_req_addr),
        .mem_resp_val(mem_resp_val), .mem_resp_transid(mem_resp_transid),
        .mem_resp_data(mem_resp_data),
        .col_idx_val(col_idx_val), .col_idx_rdy(col_idx_rdy), .col_idx_out(col_idx_out),
        .col_idx_mask(col_idx_mask), .col_idx_last(col_idx_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always_comb begin
        obs_lanes = '0;
        for (int i = 0; i < 16; i++) obs_lanes[i*16 +: 16] = col_idx_out[i];
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One fetch job against a memory model that answers outstanding requests in an order chosen
    // by mode: 0 random, 1 tags 3,1,0,2 once all four beats are requested, 2 oldest first.
    task automatic run_job(input logic [39:0] base, input int nnz, input int mode,
                           input int rrdy_pct, input int resp_pct, input int crdy_pct,
                           input int chold);
        int nb, ng, k, grp, cyc, idx, pn, g;
        bit exp_done, finished, req_stall, col_stall, coll;
        int oq_tid[$];
        int oq_beat[$];
        int perm[4];
        logic [255:0] exp_lanes;
        logic [15:0]  exp_mask;
        perm = '{3, 1, 0, 2};
        nb = (nnz + 3) / 4;
        ng = (nnz + 15) / 16;
        k = 0; grp = 0; cyc = 0; pn = 0;
        exp_done = 0; finished = 0; req_stall = 0; col_stall = 0;
        for (int j = 0; j < nb * 4; j++) mem[j] = 16'($urandom);
        idx_pntr = base;
        nnz_cnt = 16'(nnz);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start", busy, 1'b1);
        while (!finished && cyc < 4000) begin
            if (req_stall) check("req_hold", mem_req_val, 1'b1);
            if (mem_req_val) begin
                check("req_addr", mem_req_addr, base + 40'(8 * k));
                check("req_tid", mem_req_transid, 6'(k % 8));
            end
            if (col_stall) check("col_hold", col_idx_val, 1'b1);
            if (col_idx_val) begin
                for (int i = 0; i < 16; i++) begin
                    g = grp * 16 + i;
                    exp_lanes[i*16 +: 16] = (g < nnz) ? mem[g] : 16'h0;
                    exp_mask[i] = (g < nnz);
                end
                check("col_data", obs_lanes, exp_lanes);
                check("col_mask", col_idx_mask, exp_mask);
                check("col_last", col_idx_last, (grp == ng - 1));
            end
            if (done || exp_done) check("done", done, exp_done);
            if (exp_done) begin
                finished = 1;
                check("busy_end", busy, 1'b0);
            end else begin
                mem_req_rdy = ($urandom_range(99) < rrdy_pct);
                mem_resp_val = 1'b0;
                idx = -1;
                if (oq_tid.size() > 0) begin
                    if (mode == 0) begin
                        if ($urandom_range(99) < resp_pct) idx = $urandom_range(oq_tid.size() - 1);
                    end else if (mode == 1) begin
                        if (k == nb && pn < 4) begin
                            foreach (oq_tid[j]) if (oq_tid[j] == perm[pn]) idx = j;
                            if (idx >= 0) pn++;
                        end
                    end else begin
                        idx = 0;
                    end
                end
                if (idx >= 0) begin
                    mem_resp_val = 1'b1;
                    mem_resp_transid = 6'(oq_tid[idx]);
                    mem_resp_data = {mem[oq_beat[idx]*4+3], mem[oq_beat[idx]*4+2],
                                     mem[oq_beat[idx]*4+1], mem[oq_beat[idx]*4]};
                    oq_tid.delete(idx);
                    oq_beat.delete(idx);
                end
                if (mem_req_val && mem_req_rdy) begin
                    coll = (oq_tid.size() >= 8);
                    foreach (oq_tid[j]) if (oq_tid[j] == int'(mem_req_transid)) coll = 1;
                    check("tid_free", coll, 1'b0);
                    oq_tid.push_back(int'(mem_req_transid));
                    oq_beat.push_back(k);
                    k++;
                end
                req_stall = mem_req_val && !mem_req_rdy;
                col_idx_rdy = (cyc >= chold) && ($urandom_range(99) < crdy_pct);
                col_stall = col_idx_val && !col_idx_rdy;
                if (col_idx_val && col_idx_rdy) begin
                    if (grp == ng - 1) exp_done = 1;
                    grp++;
                end
                tick();
                cyc++;
            end
        end
        if (!finished) check("timeout", 1'b0, 1'b1);
        check("n_req", k, nb);
        check("n_grp", grp, ng);
        check("resp_left", oq_tid.size(), 0);
        mem_req_rdy = 1'b0;
        mem_resp_val = 1'b0;
        col_idx_rdy = 1'b0;
        tick();
        check("done_once", done, 1'b0);
    endtask

    initial begin
        int nfire, w;
        logic [39:0] base;
        rst_n = 1'b0;
        spmv_init = 1'b0; start = 1'b0; idx_pntr = '0; nnz_cnt = '0;
        mem_req_rdy = 1'b0; mem_resp_val = 1'b0; mem_resp_transid = '0; mem_resp_data = '0;
        col_idx_rdy = 1'b0;
        tick(); tick();
        check("rst_req", {mem_req_val, mem_req_transid, mem_req_addr}, '0);
        check("rst_col", {col_idx_val, col_idx_mask, col_idx_last}, '0);
        check("rst_lanes", obs_lanes, '0);
        check("rst_status", {busy, done}, '0);
        rst_n = 1'b1;
        tick();

        // Zero-length job: done next cycle, no traffic.
        nnz_cnt = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("nnz0_done", done, 1'b1);
        check("nnz0_quiet", {mem_req_val, busy}, 2'b00);
        tick();
        check("nnz0_pulse", done, 1'b0);

        run_job(40'h1000, 16, 2, 100, 100, 100, 0);
        run_job(40'h1000, 6, 2, 100, 100, 100, 0);
        run_job(40'h1000, 16, 1, 100, 100, 100, 0);
        run_job(40'h1000, 32, 0, 50, 60, 100, 20);

        // Window fills with no responses; one return frees exactly one more request.
        idx_pntr = 40'h1000; nnz_cnt = 16'd64; mem_req_rdy = 1'b1; col_idx_rdy = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        nfire = 0;
        for (int c = 0; c < 20; c++) begin
            if (mem_req_val) begin
                check("win_addr", mem_req_addr, 40'h1000 + 40'(8 * nfire));
                check("win_tid", mem_req_transid, 6'(nfire % 8));
                nfire++;
            end
            tick();
        end
        check("win_fires", nfire, 8);
        check("win_block", mem_req_val, 1'b0);
        mem_resp_val = 1'b1; mem_resp_transid = 6'd0; mem_resp_data = 64'h0004_0003_0002_0001;
        tick();
        mem_resp_val = 1'b0;
        w = 0;
        while (!mem_req_val && w < 10) begin
            tick();
            w++;
        end
        check("win_reissue", mem_req_val, 1'b1);
        check("win9_addr", mem_req_addr, 40'h1040);
        check("win9_tid", mem_req_transid, 6'd0);
        tick();
        mem_req_rdy = 1'b0;

        // Abort with eight requests in flight: busy until every response is discarded.
        spmv_init = 1'b1;
        tick();
        spmv_init = 1'b0;
        for (int r = 0; r < 8; r++) begin
            check("abort_hold", {busy, col_idx_val, done}, 3'b100);
            mem_resp_val = 1'b1;
            mem_resp_transid = 6'((r + 1) % 8);
            mem_resp_data = 64'($urandom);
            tick();
        end
        mem_resp_val = 1'b0;
        check("abort_idle", {busy, col_idx_val, done, mem_req_val}, 4'b0000);
        tick();
        check("abort_nodone", {busy, done}, 2'b00);

        for (int n = 0; n < 6; n++) begin
            base = {8'($urandom), 32'($urandom)};
            base[2:0] = 3'b000;
            run_job(base, $urandom_range(1, 200), 0, $urandom_range(30, 100),
                    $urandom_range(20, 100), $urandom_range(30, 100), $urandom_range(0, 10));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
